// File: rtl/otter_fetch_pkg.sv
// Shared types and constants for the Otter instruction-fetch front end.
package otter_fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR            = 32'h0000_0013;

  // Redirect target select coming from execute.
  typedef enum logic [2:0] {
    PC_SRC_NONE   = 3'd0,
    PC_SRC_JALR   = 3'd1,
    PC_SRC_BRANCH = 3'd2,
    PC_SRC_JAL    = 3'd3,
    PC_SRC_MTVEC  = 3'd4,
    PC_SRC_MEPC   = 3'd5
  } pc_src_e;

  // REQ: request on the bus, WAIT: one request outstanding, FULL: buffer holds an instruction.
  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_FULL = 2'd2
  } fetch_state_e;

  // Instruction presented to decode.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_payload_t;

  // Clear the two byte-offset bits so a fetch address is always word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(32'h3);
  endfunction

endpackage

// File: rtl/otter_pc_target_mux.sv
// Redirect target select and alignment check for the fetch unit.
// With OTTER_MISALIGN_TRAP_EN defined, a misaligned jal/branch/jalr target
// is replaced by MTVEC and flagged; otherwise the low target bits are dropped.
module otter_pc_target_mux
  import otter_fetch_pkg::*;
(
  input  logic            redirect,
  input  logic [2:0]      pc_source,
  input  logic [XLEN-1:0] jal,
  input  logic [XLEN-1:0] branch,
  input  logic [XLEN-1:0] jalr,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic            redirect_valid_c,
  output logic [XLEN-1:0] target_c
`ifdef OTTER_MISALIGN_TRAP_EN
  ,
  output logic            misalign_c,
  output logic [XLEN-1:0] bad_target_c
`endif
);

  logic [XLEN-1:0] raw_target;
  logic            src_valid;

  // Pick the candidate target; unused encodings do not redirect.
  always_comb begin
    raw_target = '0;
    src_valid  = 1'b0;
    case (pc_src_e'(pc_source))
      PC_SRC_JALR:   begin raw_target = jalr;   src_valid = 1'b1; end
      PC_SRC_BRANCH: begin raw_target = branch; src_valid = 1'b1; end
      PC_SRC_JAL:    begin raw_target = jal;    src_valid = 1'b1; end
      PC_SRC_MTVEC:  begin raw_target = mtvec;  src_valid = 1'b1; end
      PC_SRC_MEPC:   begin raw_target = mepc;   src_valid = 1'b1; end
      default:       begin raw_target = '0;     src_valid = 1'b0; end
    endcase
  end

`ifdef OTTER_MISALIGN_TRAP_EN
  logic ctrl_xfer;

  // Control transfers to a non-word address divert to the trap vector.
  always_comb begin
    ctrl_xfer        = (pc_source == 3'(PC_SRC_JALR))
                    || (pc_source == 3'(PC_SRC_BRANCH))
                    || (pc_source == 3'(PC_SRC_JAL));
    redirect_valid_c = redirect && src_valid;
    misalign_c       = redirect && ctrl_xfer && (raw_target[1:0] != 2'b00);
    bad_target_c     = raw_target;
    target_c         = word_align(misalign_c ? mtvec : raw_target);
  end
`else
  // Misalignment is not trapped: the byte offset is silently dropped.
  always_comb begin
    redirect_valid_c = redirect && src_valid;
    target_c         = word_align(raw_target);
  end
`endif

endmodule

// File: rtl/otter_fetch_unit.sv
// Otter MCU instruction-fetch front end: PC register, one-outstanding
// instruction-memory requests, single-entry output buffer towards decode and
// epoch-based flushing on redirects.
// Optional feature macro: OTTER_MISALIGN_TRAP_EN (trap misaligned jumps to MTVEC).
module otter_fetch_unit
  import otter_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            REDIRECT,
  input  logic [2:0]      PC_SOURCE,
  input  logic [XLEN-1:0] JAL,
  input  logic [XLEN-1:0] BRANCH,
  input  logic [XLEN-1:0] JALR,
  input  logic [XLEN-1:0] MTVEC,
  input  logic [XLEN-1:0] MEPC,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_GNT,
  input  logic            IMEM_RVALID,
  input  logic [XLEN-1:0] IMEM_RDATA,
  output logic            IF_VALID,
  output logic [XLEN-1:0] IF_PC,
  output logic [XLEN-1:0] IF_INSTR,
  input  logic            IF_READY,
  output logic            MISALIGN,
  output logic [XLEN-1:0] MISALIGN_ADDR
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            epoch_q, epoch_d;
  logic            req_epoch_q, req_epoch_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            if_valid_q, if_valid_d;
  if_payload_t     if_buf_q, if_buf_d;
  logic            imem_req_q, imem_req_d;
  logic [XLEN-1:0] imem_addr_q, imem_addr_d;

  logic            redirect_valid_c;
  logic [XLEN-1:0] target_c;

`ifdef OTTER_MISALIGN_TRAP_EN
  logic            misalign_c;
  logic [XLEN-1:0] bad_target_c;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;
`endif

  otter_pc_target_mux u_target_mux (
    .redirect         (REDIRECT),
    .pc_source        (PC_SOURCE),
    .jal              (JAL),
    .branch           (BRANCH),
    .jalr             (JALR),
    .mtvec            (MTVEC),
    .mepc             (MEPC),
    .redirect_valid_c (redirect_valid_c),
    .target_c         (target_c)
`ifdef OTTER_MISALIGN_TRAP_EN
    ,
    .misalign_c       (misalign_c),
    .bad_target_c     (bad_target_c)
`endif
  );

  // State, PC, epoch and output-buffer registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= FETCH_REQ;
      pc_q        <= RESET_VECTOR;
      epoch_q     <= 1'b0;
      req_epoch_q <= 1'b0;
      req_pc_q    <= RESET_VECTOR;
      if_valid_q  <= 1'b0;
      if_buf_q    <= '{pc: '0, instr: NOP_INSTR};
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_VECTOR;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      epoch_q     <= epoch_d;
      req_epoch_q <= req_epoch_d;
      req_pc_q    <= req_pc_d;
      if_valid_q  <= if_valid_d;
      if_buf_q    <= if_buf_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
    end
  end

  // Next-state, PC update and buffer load; a redirect overrides the normal flow.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    epoch_d     = epoch_q;
    req_epoch_d = req_epoch_q;
    req_pc_d    = req_pc_q;
    if_valid_d  = if_valid_q;
    if_buf_d    = if_buf_q;
    imem_req_d  = 1'b0;
    imem_addr_d = imem_addr_q;

    case (state_q)
      FETCH_REQ: begin
        // imem_req_q gates GNT so the first cycle after reset cannot be granted.
        if (imem_req_q && IMEM_GNT) begin
          req_epoch_d = epoch_q;
          req_pc_d    = pc_q;
          pc_d        = pc_q + XLEN'(4);
          state_d     = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (IMEM_RVALID) begin
          if ((req_epoch_q == epoch_q) && !redirect_valid_c) begin
            if_valid_d     = 1'b1;
            if_buf_d.pc    = req_pc_q;
            if_buf_d.instr = IMEM_RDATA;
            state_d        = FETCH_FULL;
          end else begin
            state_d = FETCH_REQ;
          end
        end
      end
      FETCH_FULL: begin
        if (IF_READY) begin
          if_valid_d = 1'b0;
          state_d    = FETCH_REQ;
        end
      end
      default: begin
        state_d = FETCH_REQ;
      end
    endcase

    if (redirect_valid_c) begin
      pc_d       = target_c;
      epoch_d    = ~epoch_q;
      if_valid_d = 1'b0;
      if (state_q == FETCH_FULL) begin
        state_d = FETCH_REQ;
      end
      // Pin the outstanding request to the pre-redirect epoch so that two
      // redirects in one WAIT cannot toggle the epoch back into a false match.
      if (state_d == FETCH_WAIT) begin
        req_epoch_d = epoch_q;
      end
    end

    imem_req_d  = (state_d == FETCH_REQ);
    imem_addr_d = pc_d;
  end

`ifdef OTTER_MISALIGN_TRAP_EN
  // Misalign pulse and sticky offending address.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  // Capture the raw target whenever a misaligned jump is trapped.
  always_comb begin
    misalign_d      = misalign_c;
    misalign_addr_d = misalign_addr_q;
    if (misalign_c) begin
      misalign_addr_d = bad_target_c;
    end
  end

  assign MISALIGN      = misalign_q;
  assign MISALIGN_ADDR = misalign_addr_q;
`else
  assign MISALIGN      = 1'b0;
  assign MISALIGN_ADDR = '0;
`endif

  assign IMEM_REQ  = imem_req_q;
  assign IMEM_ADDR = imem_addr_q;
  assign IF_VALID  = if_valid_q;
  assign IF_PC     = if_buf_q.pc;
  assign IF_INSTR  = if_buf_q.instr;

endmodule

// File: tb/tb_otter_fetch_unit.sv
// Testbench for otter_fetch_unit: directed scenarios followed by randomized
// traffic checked against an architectural model of the instruction stream.
module tb_otter_fetch_unit;

  logic        CLK;
  logic        RST_N;
  logic        REDIRECT;
  logic [2:0]  PC_SOURCE;
  logic [31:0] JAL, BRANCH, JALR, MTVEC, MEPC;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT;
  logic        IMEM_RVALID;
  logic [31:0] IMEM_RDATA;
  logic        IF_VALID;
  logic [31:0] IF_PC;
  logic [31:0] IF_INSTR;
  logic        IF_READY;
  logic        MISALIGN;
  logic [31:0] MISALIGN_ADDR;

  int checks = 0;
  int errors = 0;

  otter_fetch_unit dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .REDIRECT      (REDIRECT),
    .PC_SOURCE     (PC_SOURCE),
    .JAL           (JAL),
    .BRANCH        (BRANCH),
    .JALR          (JALR),
    .MTVEC         (MTVEC),
    .MEPC          (MEPC),
    .IMEM_REQ      (IMEM_REQ),
    .IMEM_ADDR     (IMEM_ADDR),
    .IMEM_GNT      (IMEM_GNT),
    .IMEM_RVALID   (IMEM_RVALID),
    .IMEM_RDATA    (IMEM_RDATA),
    .IF_VALID      (IF_VALID),
    .IF_PC         (IF_PC),
    .IF_INSTR      (IF_INSTR),
    .IF_READY      (IF_READY),
    .MISALIGN      (MISALIGN),
    .MISALIGN_ADDR (MISALIGN_ADDR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  // Instruction memory contents as a function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural effect of a redirect request: is it taken, where does fetch resume, does it trap.
  function automatic void model_redirect(input logic [2:0] src,
                                         input logic [31:0] jal_t, br_t, jalr_t, mtvec_t, mepc_t,
                                         output bit v, output logic [31:0] tgt,
                                         output bit mis, output logic [31:0] raw);
    v   = 1'b1;
    mis = 1'b0;
    case (src)
      3'd1: raw = jalr_t;
      3'd2: raw = br_t;
      3'd3: raw = jal_t;
      3'd4: raw = mtvec_t;
      3'd5: raw = mepc_t;
      default: begin v = 1'b0; raw = 32'h0; end
    endcase
    tgt = {raw[31:2], 2'b00};
`ifdef OTTER_MISALIGN_TRAP_EN
    if (v && src >= 3'd1 && src <= 3'd3 && raw[1:0] != 2'b00) begin
      mis = 1'b1;
      tgt = {mtvec_t[31:2], 2'b00};
    end
`endif
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(7, 0) == 0) t = 32'hFFFF_FFF8;
    if ($urandom_range(3, 0) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  // One zero-wait fetch at pc, then optionally stall decode for 'stall' cycles.
  // Entered and left on a falling edge with the unit requesting.
  task automatic fetch_one(input logic [31:0] pc, input int stall);
    chk("req_hi", 32'(IMEM_REQ), 32'd1);
    chk("req_addr", IMEM_ADDR, pc);
    IMEM_GNT = 1'b1;
    @(negedge CLK);
    IMEM_GNT    = 1'b0;
    IMEM_RVALID = 1'b1;
    IMEM_RDATA  = mem_word(pc);
    IF_READY    = (stall == 0);
    @(negedge CLK);
    IMEM_RVALID = 1'b0;
    IMEM_RDATA  = 32'h0;
    chk("if_valid", 32'(IF_VALID), 32'd1);
    chk("if_pc", IF_PC, pc);
    chk("if_instr", IF_INSTR, mem_word(pc));
    chk("full_no_req", 32'(IMEM_REQ), 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge CLK);
      chk("hold_valid", 32'(IF_VALID), 32'd1);
      chk("hold_pc", IF_PC, pc);
      chk("hold_instr", IF_INSTR, mem_word(pc));
      chk("hold_no_req", 32'(IMEM_REQ), 32'd0);
    end
    IF_READY = 1'b1;
    @(negedge CLK);
  endtask

  logic [31:0] exp5;
  logic [31:0] exp_pc, exp_mis_addr;
  bit          exp_mis, prev_hold;
  int          idle;
  bit          pend;
  logic [31:0] pend_addr;
  int          pend_dly, req_wait;
  bit          rv;
  logic [31:0] rtgt, rraw;
  bit          rmis;

  initial begin
    RST_N = 1'b0; REDIRECT = 1'b0; PC_SOURCE = 3'd0;
    JAL = 32'h0; BRANCH = 32'h0; JALR = 32'h0; MTVEC = 32'h0; MEPC = 32'h0;
    IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; IMEM_RDATA = 32'h0; IF_READY = 1'b1;
    repeat (2) @(negedge CLK);

    // Reset values
    chk("rst_req", 32'(IMEM_REQ), 32'd0);
    chk("rst_addr", IMEM_ADDR, 32'h0);
    chk("rst_valid", 32'(IF_VALID), 32'd0);
    chk("rst_pc", IF_PC, 32'h0);
    chk("rst_instr", IF_INSTR, 32'h0000_0013);
    chk("rst_mis", 32'(MISALIGN), 32'd0);
    chk("rst_mis_addr", MISALIGN_ADDR, 32'h0);

    RST_N = 1'b1;
    @(negedge CLK);

    // Sequential fetch at best-case throughput
    fetch_one(32'h0, 0);
    fetch_one(32'h4, 0);
    fetch_one(32'h8, 0);
    // Decode stall keeps the buffer stable and the bus idle
    fetch_one(32'hC, 5);

    // Redirect while a request is outstanding
    chk("t3_addr", IMEM_ADDR, 32'h10);
    IMEM_GNT = 1'b1;
    @(negedge CLK);
    IMEM_GNT = 1'b0; REDIRECT = 1'b1; PC_SOURCE = 3'd3; JAL = 32'h100;
    @(negedge CLK);
    REDIRECT = 1'b0; PC_SOURCE = 3'd0;
    chk("t3_wait_no_req", 32'(IMEM_REQ), 32'd0);
    IMEM_RVALID = 1'b1; IMEM_RDATA = 32'hDEAD_BEEF;
    @(negedge CLK);
    IMEM_RVALID = 1'b0;
    chk("t3_stale_dropped", 32'(IF_VALID), 32'd0);
    fetch_one(32'h100, 0);

    // Redirect in the same cycle as the grant
    chk("t4_addr", IMEM_ADDR, 32'h104);
    IMEM_GNT = 1'b1; REDIRECT = 1'b1; PC_SOURCE = 3'd2; BRANCH = 32'h40;
    @(negedge CLK);
    IMEM_GNT = 1'b0; REDIRECT = 1'b0; PC_SOURCE = 3'd0;
    chk("t4_wait_no_req", 32'(IMEM_REQ), 32'd0);
    IMEM_RVALID = 1'b1; IMEM_RDATA = 32'hBAD0_0104;
    @(negedge CLK);
    IMEM_RVALID = 1'b0;
    chk("t4_gnt_dropped", 32'(IF_VALID), 32'd0);
    fetch_one(32'h40, 0);

    // Misaligned jalr target
    REDIRECT = 1'b1; PC_SOURCE = 3'd1; JALR = 32'h202; MTVEC = 32'h800;
    @(negedge CLK);
    REDIRECT = 1'b0; PC_SOURCE = 3'd0;
`ifdef OTTER_MISALIGN_TRAP_EN
    exp5 = 32'h800;
    chk("t5_mis", 32'(MISALIGN), 32'd1);
    chk("t5_mis_addr", MISALIGN_ADDR, 32'h202);
`else
    exp5 = 32'h200;
    chk("t5_mis", 32'(MISALIGN), 32'd0);
    chk("t5_mis_addr", MISALIGN_ADDR, 32'h0);
`endif
    chk("t5_addr", IMEM_ADDR, exp5);
    @(negedge CLK);
    chk("t5_mis_pulse", 32'(MISALIGN), 32'd0);
`ifdef OTTER_MISALIGN_TRAP_EN
    chk("t5_mis_held", MISALIGN_ADDR, 32'h202);
`else
    chk("t5_mis_held", MISALIGN_ADDR, 32'h0);
`endif
    fetch_one(exp5, 0);

    // Reset in the middle of an outstanding request
    IMEM_GNT = 1'b1;
    @(negedge CLK);
    IMEM_GNT = 1'b0; RST_N = 1'b0;
    #1;
    chk("t6_rst_req", 32'(IMEM_REQ), 32'd0);
    chk("t6_rst_addr", IMEM_ADDR, 32'h0);
    chk("t6_rst_mis_addr", MISALIGN_ADDR, 32'h0);
    @(negedge CLK);
    RST_N = 1'b1; IMEM_RVALID = 1'b1; IMEM_RDATA = mem_word(exp5 + 32'd4);
    @(negedge CLK);
    IMEM_RVALID = 1'b0;
    chk("t6_resp_ignored", 32'(IF_VALID), 32'd0);
    chk("t6_req", 32'(IMEM_REQ), 32'd1);
    chk("t6_addr", IMEM_ADDR, 32'h0);
    fetch_one(32'h0, 0);

    // Randomized traffic against the instruction-stream model
    exp_pc = 32'h4; exp_mis = 1'b0; exp_mis_addr = 32'h0;
    prev_hold = 1'b0; idle = 0; pend = 1'b0; pend_addr = 32'h0; pend_dly = 0; req_wait = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (IF_VALID) begin
        chk("r_pc", IF_PC, exp_pc);
        chk("r_instr", IF_INSTR, mem_word(exp_pc));
      end
      if (prev_hold) chk("r_hold", 32'(IF_VALID), 32'd1);
      chk("r_mis", 32'(MISALIGN), 32'(exp_mis));
      chk("r_mis_addr", MISALIGN_ADDR, exp_mis_addr);
      if (IMEM_REQ) begin
        chk("r_req_align", 32'(IMEM_ADDR[1:0]), 32'd0);
        chk("r_req_while_full", 32'(IF_VALID), 32'd0);
      end
      chk("r_starve", 32'(idle > 30), 32'd0);

      IF_READY  = ($urandom_range(3, 0) != 0);
      REDIRECT  = ($urandom_range(9, 0) == 0);
      PC_SOURCE = 3'($urandom_range(7, 0));
      JAL = rand_target(); BRANCH = rand_target(); JALR = rand_target();
      MTVEC = rand_target(); MEPC = rand_target();
      IMEM_RVALID = pend && (pend_dly == 0);
      IMEM_RDATA  = IMEM_RVALID ? mem_word(pend_addr) : $urandom;
      IMEM_GNT    = IMEM_REQ && !pend && ((req_wait >= 3) || ($urandom_range(1, 0) == 1));

      model_redirect(PC_SOURCE, JAL, BRANCH, JALR, MTVEC, MEPC, rv, rtgt, rmis, rraw);
      rv      = rv && REDIRECT;
      exp_mis = rv && rmis;
      if (exp_mis) exp_mis_addr = rraw;
      if (IF_VALID && IF_READY) exp_pc = exp_pc + 32'd4;
      if (rv) exp_pc = rtgt;
      prev_hold = IF_VALID && !IF_READY && !rv;
      idle      = (IF_VALID || rv) ? 0 : idle + 1;

      if (IMEM_RVALID) pend = 1'b0;
      else if (pend) pend_dly--;
      if (IMEM_GNT) begin
        pend = 1'b1; pend_addr = IMEM_ADDR; pend_dly = $urandom_range(2, 0);
      end
      req_wait = (IMEM_REQ && !IMEM_GNT) ? req_wait + 1 : 0;
      @(negedge CLK);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
